fxp400_series_unit: RTL and testbench
=====================================

// Module: fxp400_series_unit
// PURPOSE
//   Fixed-point arithmetic datapath for the e-series calculator: 400-bit unsigned constant ONE,
//   a 400-bit / 8-bit sequential divider and a 400-bit adder, each with its own start/done handshake.
//   The series controller loads ONE, divides it by a small integer and accumulates the quotient.
//   The divider and the adder run independently and may be active at the same time.
// PARAMETERS
//   W      400  datapath width (bits)
//   FRAC   392  fractional bits; format is unsigned Q(W-FRAC).FRAC, so ONE = 1 << FRAC
//   DW     8    divisor width (bits)
// PORTS
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous, active-low reset
//   one        out  W    constant ONE (1 << FRAC); combinational, independent of reset
//   div_start  in   1    divide request, sampled on clk
//   dividend   in   W    unsigned dividend, captured when div_start is accepted
//   divisor    in   DW   unsigned divisor, captured when div_start is accepted
//   quotient   out  W    floor(dividend / divisor)
//   div_busy   out  1    high while a division is in progress
//   div_done   out  1    one-cycle completion pulse
//   add_start  in   1    add request, sampled on clk
//   add_a      in   W    addend A, captured when add_start is accepted
//   add_b      in   W    addend B, captured when add_start is accepted
//   sum        out  W    (add_a + add_b) mod 2^W
//   add_done   out  1    one-cycle completion pulse
// BEHAVIOUR
//   - Reset (rst_n low, async): quotient=0, sum=0, div_busy=0, div_done=0, add_done=0, divider FSM=IDLE.
//     Reset mid-operation aborts the operation. No done pulse is produced for the aborted operation.
//   - Divider FSM: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: div_start=1 at edge k captures operands, clears the 9-bit remainder, sets div_busy, goes to RUN.
//     RUN: restoring long division, one quotient bit per clock, dividend MSB first, W iterations
//     (edges k+1..k+W). Each step: rem = {rem, next bit}; if rem >= divisor then subtract and qbit=1.
//     DONE: at edge k+W, quotient is written, div_busy drops and div_done is high for exactly one cycle.
//     The next accepted start can be at edge k+W+1.
//   - quotient holds its value until the next completion. It is never updated partially while RUN
//     shifts internally (internal register separate from the output).
//   - div_start while busy or in DONE is ignored (no queueing).
//   - divisor==0: the full W-cycle run still executes. Result quotient = all ones, remainder ignored.
//   - Adder: add_start=1 at edge k -> at edge k, sum <= add_a+add_b and add_done <= 1.
//     add_done is high for exactly one cycle (cleared at edge k+1 unless add_start is high again).
//     Back-to-back starts are legal: one result per cycle.
//     Carry out of bit W-1 is discarded (wrap-around). sum holds between operations.
//   - The done pulses must never be sticky. A controller that re-issues start and then polls done
//     must not see a stale done from the previous operation.
//   - Simultaneous div_start and add_start: both are accepted and do not interact.
// STRUCTURE
//   - Package fxp400_pkg: W, FRAC, DW, localparam ONE = W'(1) << FRAC, divider state enum
//     {IDLE, RUN, DONE}.
//   - One sub-module is natural: fxp400_div_core (sequential restoring divider with FSM,
//     bit counter and remainder).
//   - The adder and the ONE constant stay inline in the top.
// TESTING
//   1. one == 1<<392 immediately after reset; quotient=sum=0, dones=0, div_busy=0.
//   2. dividend=ONE, divisor=1 -> after 400 cycles quotient=ONE, exactly one div_done pulse,
//      div_busy high for 400 cycles.
//   3. dividend=ONE, divisor=3 -> quotient=floor(2^392/3); divisor=70 -> floor(2^392/70).
//      Remainder check: dividend - q*divisor < divisor.
//   4. add ONE+ONE -> sum=2<<392 one cycle later with a single add_done pulse.
//      Add all-ones + 1 -> sum=0 (wrap).
//   5. divisor=0 -> quotient=all ones after 400 cycles. div_start pulsed mid-run -> ignored,
//      only one done pulse.
//   6. rst_n low mid-division -> busy=0, quotient=0, no done pulse.
//      Restart: full series loop (ONE/n accumulated, n=1..70) matches a reference model bit-exactly.

Source files
------------

// File: rtl/fxp400_pkg.sv
// ---------------------------------------------------------------------------
// fxp400_pkg
//   Shared parameters, the divider state encoding and the single-step
//   restoring-division helper used by the e-series fixed-point datapath.
//   Format is unsigned Q(W-FRAC).FRAC, so ONE = 1 << FRAC.
// ---------------------------------------------------------------------------
package fxp400_pkg;

    localparam int W     = 400;      // datapath width
    localparam int FRAC  = 392;      // fractional bits
    localparam int DW    = 8;        // divisor width
    localparam int REM_W = DW + 1;   // partial remainder width (one guard bit)
    localparam int CW    = 9;        // iteration counter width (W-1 fits)

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [REM_W-1:0] rem;
        logic             qbit;
    } div_step_t;

    // One restoring-division step: shift the next dividend bit into the
    // remainder and subtract the divisor when it fits. With a zero divisor
    // the compare always succeeds, which yields an all-ones quotient.
    function automatic div_step_t div_step(
        input logic [REM_W-1:0] rem,
        input logic             in_bit,
        input logic [DW-1:0]    dvs
    );
        div_step_t        res;
        logic [REM_W-1:0] shifted;
        shifted = {rem[REM_W-2:0], in_bit};
        if (shifted >= {1'b0, dvs}) begin
            res.rem  = shifted - {1'b0, dvs};
            res.qbit = 1'b1;
        end else begin
            res.rem  = shifted;
            res.qbit = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fxp400_div_core.sv
// ---------------------------------------------------------------------------
// fxp400_div_core
//   Sequential W-bit / DW-bit restoring divider, one quotient bit per clock,
//   dividend MSB first.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     start             request; accepted only in IDLE
//     dividend, divisor operands, captured on acceptance
//     quotient          registered result, updated only on completion
//     busy              high from acceptance until the completion edge
//     done              one-cycle completion pulse
//   Timing: accepted at edge k, iterations at edges k+1..k+W. RUN covers the
//   first W-1 iterations; DONE is the state holding the final iteration, so
//   the final edge writes quotient, drops busy and raises done, and the FSM
//   is back in IDLE ready to accept at edge k+W+1.
// ---------------------------------------------------------------------------
module fxp400_div_core
    import fxp400_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic [W-1:0]  quotient,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] LAST_RUN_CNT = CW'(W - 2);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    div_state_e       state_r;
    div_state_e       state_next_s;
    logic [W-1:0]     work_r;      // dividend shifts out at MSB, quotient shifts in at LSB
    logic [DW-1:0]    divisor_r;
    logic [REM_W-1:0] rem_r;
    logic [CW-1:0]    cnt_r;
    logic [W-1:0]     quotient_r;
    logic             busy_r;
    logic             done_r;
    div_step_t        step_s;

    // Next-state logic and the combinational division step.
    always_comb begin
        state_next_s = state_r;
        step_s       = div_step(rem_r, work_r[W-1], divisor_r);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_RUN_CNT) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r     <= {W{1'b0}};
            divisor_r  <= {DW{1'b0}};
            rem_r      <= {REM_W{1'b0}};
            cnt_r      <= {CW{1'b0}};
            quotient_r <= {W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        work_r    <= dividend;
                        divisor_r <= divisor;
                        rem_r     <= {REM_W{1'b0}};
                        cnt_r     <= {CW{1'b0}};
                        busy_r    <= 1'b1;
                    end
                end
                RUN: begin
                    work_r <= {work_r[W-2:0], step_s.qbit};
                    rem_r  <= step_s.rem;
                    cnt_r  <= cnt_r + CNT_ONE;
                end
                DONE: begin
                    quotient_r <= {work_r[W-2:0], step_s.qbit};
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign quotient = quotient_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: rtl/fxp400_series_unit.sv
// ---------------------------------------------------------------------------
// fxp400_series_unit
//   Fixed-point datapath for the e-series calculator: constant ONE, a
//   sequential W/DW divider and a single-cycle W-bit adder, each with its own
//   start/done handshake. Divider and adder are fully independent.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     one                         constant 1 << FRAC (not reset dependent)
//     div_start/dividend/divisor  divide request and operands
//     quotient/div_busy/div_done  divide result, busy flag, done pulse
//     add_start/add_a/add_b       add request and operands
//     sum/add_done                wrapped sum and done pulse
// ---------------------------------------------------------------------------
module fxp400_series_unit
    import fxp400_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    output logic [W-1:0]  one,
    input  logic          div_start,
    input  logic [W-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic [W-1:0]  quotient,
    output logic          div_busy,
    output logic          div_done,
    input  logic          add_start,
    input  logic [W-1:0]  add_a,
    input  logic [W-1:0]  add_b,
    output logic [W-1:0]  sum,
    output logic          add_done
);

    logic [W-1:0] sum_r;
    logic         add_done_r;

    assign one = ONE;

    fxp400_div_core u_div_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .busy     (div_busy),
        .done     (div_done)
    );

    // Adder: result and done pulse registered on the accepting edge; the
    // pulse follows add_start so back-to-back requests give one result each.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r      <= {W{1'b0}};
            add_done_r <= 1'b0;
        end else begin
            add_done_r <= add_start;
            if (add_start) begin
                sum_r <= add_a + add_b;
            end
        end
    end

    assign sum      = sum_r;
    assign add_done = add_done_r;

endmodule

// File: tb/tb_fxp400_series_unit.sv
// ---------------------------------------------------------------------------
// tb_fxp400_series_unit
//   Directed self-checking bench for fxp400_series_unit.
// ---------------------------------------------------------------------------
module tb_fxp400_series_unit;

    localparam int TW = 400;

    logic          clk;
    logic          rst_n;
    logic [TW-1:0] one;
    logic          div_start;
    logic [TW-1:0] dividend;
    logic [7:0]    divisor;
    logic [TW-1:0] quotient;
    logic          div_busy;
    logic          div_done;
    logic          add_start;
    logic [TW-1:0] add_a;
    logic [TW-1:0] add_b;
    logic [TW-1:0] sum;
    logic          add_done;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [TW-1:0] one_c;
    logic [TW-1:0] all_ones_c;

    fxp400_series_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .one       (one),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .sum       (sum),
        .add_done  (add_done)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            checks_passed++;
        end
    endtask

    // Issue one division and watch 410 cycles, counting busy and done.
    // Optionally pulses a second (to be ignored) request mid-run.
    task automatic run_div(input logic [TW-1:0] dvd, input logic [7:0] dvs, input bit mid,
                           output int busy_cnt, output int done_cnt);
        @(negedge clk);
        dividend  = dvd;
        divisor   = dvs;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        busy_cnt  = 0;
        done_cnt  = 0;
        for (int i = 0; i < 410; i++) begin
            if (div_busy) busy_cnt++;
            if (div_done) done_cnt++;
            if (mid && i == 100) begin
                div_start = 1'b1;
                divisor   = 8'd5;
                dividend  = one_c;
            end else begin
                div_start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Issue one add; report sum and add_done one cycle later and the cycle after.
    task automatic run_add(input logic [TW-1:0] a, input logic [TW-1:0] b,
                           output logic [TW-1:0] s, output logic d1, output logic d2);
        @(negedge clk);
        add_a     = a;
        add_b     = b;
        add_start = 1'b1;
        @(negedge clk);
        s         = sum;
        d1        = add_done;
        add_start = 1'b0;
        @(negedge clk);
        d2 = add_done;
    endtask

    initial begin
        int            bc;
        int            dc;
        int            total_dones;
        logic [TW-1:0] s;
        logic [TW-1:0] q;
        logic [TW-1:0] r;
        logic [TW-1:0] acc_ref;
        logic          d1;
        logic          d2;

        one_c      = TW'(1) << 392;
        all_ones_c = ~(TW'(0));

        rst_n     = 1'b0;
        div_start = 1'b0;
        add_start = 1'b0;
        dividend  = '0;
        divisor   = 8'd0;
        add_a     = '0;
        add_b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Reset state
        check("one_const", one, one_c);
        check("rst_quotient", quotient, TW'(0));
        check("rst_sum", sum, TW'(0));
        check("rst_div_done", TW'(div_done), TW'(0));
        check("rst_add_done", TW'(add_done), TW'(0));
        check("rst_div_busy", TW'(div_busy), TW'(0));

        // 2. ONE / 1
        run_div(one_c, 8'd1, 1'b0, bc, dc);
        check("div1_q", quotient, one_c);
        check("div1_busy_cycles", TW'(bc), TW'(400));
        check("div1_done_pulses", TW'(dc), TW'(1));

        // 3. ONE / 3 and ONE / 70 with remainder bound
        run_div(one_c, 8'd3, 1'b0, bc, dc);
        check("div3_q", quotient, one_c / TW'(3));
        r = one_c - quotient * TW'(3);
        check("div3_rem_lt", TW'(r < TW'(3)), TW'(1));
        run_div(one_c, 8'd70, 1'b0, bc, dc);
        check("div70_q", quotient, one_c / TW'(70));
        r = one_c - quotient * TW'(70);
        check("div70_rem_lt", TW'(r < TW'(70)), TW'(1));
        check("div70_done_pulses", TW'(dc), TW'(1));

        // 4. Adds, including wrap-around and back-to-back
        run_add(one_c, one_c, s, d1, d2);
        check("add_one_one", s, TW'(2) << 392);
        check("add_done_pulse", TW'(d1), TW'(1));
        check("add_done_clear", TW'(d2), TW'(0));
        run_add(all_ones_c, TW'(1), s, d1, d2);
        check("add_wrap", s, TW'(0));
        @(negedge clk);
        add_a = TW'(5); add_b = TW'(7); add_start = 1'b1;
        @(negedge clk);
        check("b2b_sum1", sum, TW'(12));
        check("b2b_done1", TW'(add_done), TW'(1));
        add_a = one_c; add_b = TW'(3);
        @(negedge clk);
        add_start = 1'b0;
        check("b2b_sum2", sum, one_c + TW'(3));
        check("b2b_done2", TW'(add_done), TW'(1));
        @(negedge clk);
        check("b2b_done_clear", TW'(add_done), TW'(0));
        check("sum_hold", sum, one_c + TW'(3));

        // 5. Divide by zero with an ignored mid-run request
        run_div(one_c, 8'd0, 1'b1, bc, dc);
        check("div0_q", quotient, all_ones_c);
        check("div0_done_pulses", TW'(dc), TW'(1));
        check("div0_busy_cycles", TW'(bc), TW'(400));

        // Simultaneous divide and add
        @(negedge clk);
        dividend = one_c; divisor = 8'd7; div_start = 1'b1;
        add_a = TW'(100); add_b = TW'(23); add_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0; add_start = 1'b0;
        check("sim_sum", sum, TW'(123));
        check("sim_add_done", TW'(add_done), TW'(1));
        check("sim_div_busy", TW'(div_busy), TW'(1));
        dc = 0;
        for (int i = 0; i < 410 && dc == 0; i++) begin
            @(negedge clk);
            if (div_done) dc++;
        end
        check("sim_div_done_seen", TW'(dc), TW'(1));
        check("sim_div_q", quotient, one_c / TW'(7));

        // 6. Reset mid-division
        @(negedge clk);
        dividend = one_c; divisor = 8'd9; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", TW'(div_busy), TW'(0));
        check("rst_mid_q", quotient, TW'(0));
        check("rst_mid_sum", sum, TW'(0));
        check("rst_mid_done", TW'(div_done), TW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 420; i++) begin
            @(negedge clk);
            if (div_done) dc++;
        end
        check("rst_mid_no_done", TW'(dc), TW'(0));

        // Full series: acc = sum over n=1..70 of floor(ONE / n)
        acc_ref     = '0;
        total_dones = 0;
        for (int n = 1; n <= 70; n++) begin
            run_div(one_c, 8'(n), 1'b0, bc, dc);
            total_dones += dc;
            q = quotient;
            run_add(sum, q, s, d1, d2);
            acc_ref = acc_ref + one_c / TW'(n);
        end
        check("series_sum", sum, acc_ref);
        check("series_done_count", TW'(total_dones), TW'(70));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
